// File: rtl/tt_um_emern_vga_pkg.sv
// Shared raster timing constants and helpers for the VGA timing generator.
package tt_um_emern_vga_pkg;

    // Default 640x480 @ 60 Hz mode, in pixels and lines
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Sync assertion level
    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    // Total count of one axis (active + porches + sync)
    function automatic int unsigned vga_total(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int unsigned vga_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tt_um_emern_tick_div.sv
// Pixel-clock prescaler: tick_o is high on one clock out of every PIX_DIV.
module tt_um_emern_tick_div
    import tt_um_emern_vga_pkg::*;
#(
    parameter int unsigned PIX_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CW = vga_width(PIX_DIV);
    localparam logic [CW-1:0] TC = CW'(PIX_DIV - 1);

    if (PIX_DIV < 1) begin : g_bad_pix_div
        $error("PIX_DIV must be at least 1");
    end

    logic [CW-1:0] count_q, count_d;

    // Terminal count raises the tick; with PIX_DIV = 1 the count stays 0 so tick is constant
    always_comb begin
        tick_o  = (count_q == TC);
        count_d = (clr_i || tick_o) ? '0 : count_q + 1'b1;
    end

    // Prescaler count register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tt_um_emern_vga_timing.sv
// Parametrised raster timing generator: counters, syncs, blanking, command window, strobes.
module tt_um_emern_vga_timing
    import tt_um_emern_vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter bit          SYNC_POL  = SYNC_ACTIVE_LOW,
    parameter int unsigned PIX_DIV   = 1,
    parameter int unsigned CMD_LINES = 8,
    parameter int unsigned FRAME_W   = 8,
    localparam int unsigned H_TOTAL  = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int unsigned V_TOTAL  = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int unsigned HW       = vga_width(H_TOTAL),
    localparam int unsigned VW       = vga_width(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic [HW-1:0]      col_counter,
    output logic [VW-1:0]      row_counter,
    output logic               h_sync,
    output logic               v_sync,
    output logic               screen_inactive,
    output logic               cmd_en,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam int unsigned CMD_END      = V_ACTIVE + CMD_LINES;

    if (CMD_LINES < 1 || CMD_LINES > V_FP + V_SYNC + V_BP) begin : g_bad_cmd_lines
        $error("CMD_LINES must lie in 1..V_FP+V_SYNC+V_BP");
    end

    logic tick;
    logic adv, col_wrap, row_wrap;
    logic h_act, v_act;

    logic [HW-1:0]      col_q, col_d;
    logic [VW-1:0]      row_q, row_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               h_sync_q, h_sync_d;
    logic               v_sync_q, v_sync_d;
    logic               inactive_q, inactive_d;
    logic               cmd_en_q, cmd_en_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;

    // Stopping the raster clears the prescaler so a restart begins a full pixel period
    tt_um_emern_tick_div #(
        .PIX_DIV(PIX_DIV)
    ) u_tick_div (
        .clk   (clk),
        .rst   (rst),
        .clr_i (~run),
        .tick_o(tick)
    );

    // Counter next-state: column wraps into row, row wraps into frame count
    always_comb begin
        adv      = run && tick;
        col_wrap = (col_q == HW'(H_TOTAL - 1));
        row_wrap = (row_q == VW'(V_TOTAL - 1));
        col_d    = col_q;
        row_d    = row_q;
        frame_d  = frame_q;
        if (adv) begin
            if (col_wrap) begin
                col_d = '0;
                if (row_wrap) begin
                    row_d   = '0;
                    frame_d = frame_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Output decode from next-state counters so flags and counters update on the same edge
    always_comb begin
        h_act = (32'(col_d) >= H_SYNC_START) && (32'(col_d) < H_SYNC_END);
        v_act = (32'(row_d) >= V_SYNC_START) && (32'(row_d) < V_SYNC_END);
        h_sync_d      = !SYNC_POL;
        v_sync_d      = !SYNC_POL;
        inactive_d    = 1'b1;
        cmd_en_d      = 1'b1;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (run) begin
            h_sync_d      = h_act ? SYNC_POL : !SYNC_POL;
            v_sync_d      = v_act ? SYNC_POL : !SYNC_POL;
            inactive_d    = (32'(col_d) >= H_ACTIVE) || (32'(row_d) >= V_ACTIVE);
            cmd_en_d      = (32'(row_d) >= V_ACTIVE) && (32'(row_d) < CMD_END);
            line_start_d  = adv && col_wrap;
            frame_start_d = adv && col_wrap && row_wrap;
        end
    end

    // State and output registers; reset wins over run
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q         <= '0;
            row_q         <= '0;
            frame_q       <= '0;
            h_sync_q      <= !SYNC_POL;
            v_sync_q      <= !SYNC_POL;
            inactive_q    <= 1'b0;
            cmd_en_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            frame_q       <= frame_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            inactive_q    <= inactive_d;
            cmd_en_q      <= cmd_en_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign col_counter     = col_q;
    assign row_counter     = row_q;
    assign frame_count     = frame_q;
    assign h_sync          = h_sync_q;
    assign v_sync          = v_sync_q;
    assign screen_inactive = inactive_q;
    assign cmd_en          = cmd_en_q;
    assign line_start      = line_start_q;
    assign frame_start     = frame_start_q;

endmodule

// File: tb/tb_tt_um_emern_vga_timing.sv
// Scoreboard bench: three timing generators (default mode, PIX_DIV=2 active-high, tiny mode).
module tb_tt_um_emern_vga_timing;
    import tt_um_emern_vga_pkg::*;

    typedef struct {
        int unsigned stamp;
        int unsigned v1;
        int unsigned v2;
        int unsigned v3;
    } ev_t;

    logic        clk = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int unsigned base, base2;

    ev_t q_la[$];
    ev_t q_lb[$];
    ev_t q_lc[$];
    ev_t q_sa[$];

    logic       rst_a, run_a, hs_a, vs_a, in_a, cmd_a, ls_a, fs_a;
    logic [9:0] col_a, row_a;
    logic [7:0] fc_a;
    logic       rst_b, run_b, hs_b, vs_b, in_b, cmd_b, ls_b, fs_b;
    logic [9:0] col_b, row_b;
    logic [7:0] fc_b;
    logic       rst_c, run_c, hs_c, vs_c, in_c, cmd_c, ls_c, fs_c;
    logic [3:0] col_c;
    logic [2:0] row_c;
    logic [1:0] fc_c;

    tt_um_emern_vga_timing u_dut_a (
        .clk(clk), .rst(rst_a), .run(run_a), .col_counter(col_a), .row_counter(row_a),
        .h_sync(hs_a), .v_sync(vs_a), .screen_inactive(in_a), .cmd_en(cmd_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
    );

    tt_um_emern_vga_timing #(.SYNC_POL(SYNC_ACTIVE_HIGH), .PIX_DIV(2)) u_dut_b (
        .clk(clk), .rst(rst_b), .run(run_b), .col_counter(col_b), .row_counter(row_b),
        .h_sync(hs_b), .v_sync(vs_b), .screen_inactive(in_b), .cmd_en(cmd_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
    );

    tt_um_emern_vga_timing #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CMD_LINES(3), .FRAME_W(2)
    ) u_dut_c (
        .clk(clk), .rst(rst_c), .run(run_c), .col_counter(col_c), .row_counter(row_c),
        .h_sync(hs_c), .v_sync(vs_c), .screen_inactive(in_c), .cmd_en(cmd_c),
        .line_start(ls_c), .frame_start(fs_c), .frame_count(fc_c)
    );

    always #5 clk = ~clk;

    // Clock count used to time-stamp observed events
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL timeout: got no end of test, expected finish before 500000");
        $fatal(1, "timeout");
    end

    function automatic ev_t mk(input int unsigned s, input int unsigned a,
                               input int unsigned b, input int unsigned c);
        ev_t e;
        e.stamp = s;
        e.v1    = a;
        e.v2    = b;
        e.v3    = c;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic unexp(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: got an event at cycle %0d, expected none", nm, cyc);
    endtask

    task automatic line_cmp(input string nm, input ev_t e, input logic [31:0] col,
                            input logic [31:0] row, input logic [31:0] fs,
                            input logic [31:0] fc);
        chk({nm, "_ls_cycle"}, cyc, e.stamp);
        chk({nm, "_ls_col"}, col, 0);
        chk({nm, "_ls_row"}, row, e.v1);
        chk({nm, "_ls_frame_start"}, fs, e.v2);
        chk({nm, "_ls_frame_count"}, fc, e.v3);
    endtask

    task automatic chk_rst(input string nm, input logic [31:0] col, input logic [31:0] row,
                           input logic [31:0] fc, input logic hs, input logic vs,
                           input logic inact, input logic cmd, input logic ls,
                           input logic fs, input logic idle_lvl);
        chk({nm, "_rst_col"}, col, 0);
        chk({nm, "_rst_row"}, row, 0);
        chk({nm, "_rst_frame"}, fc, 0);
        chk({nm, "_rst_hsync"}, 32'(hs), 32'(idle_lvl));
        chk({nm, "_rst_vsync"}, 32'(vs), 32'(idle_lvl));
        chk({nm, "_rst_inactive"}, 32'(inact), 0);
        chk({nm, "_rst_cmd_en"}, 32'(cmd), 0);
        chk({nm, "_rst_line_start"}, 32'(ls), 0);
        chk({nm, "_rst_frame_start"}, 32'(fs), 0);
    endtask

    task automatic at_cyc(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    // Line-start monitors: pop the expected strobe and compare position and frame state
    always @(negedge clk) begin
        if (ls_a === 1'b1) begin
            if (q_la.size() == 0) unexp("a_line_start");
            else line_cmp("a", q_la.pop_front(), 32'(col_a), 32'(row_a), 32'(fs_a), 32'(fc_a));
        end
        if (fs_a === 1'b1) chk("a_fs_with_ls", 32'(ls_a), 1);
    end

    // Monitor for the PIX_DIV=2 instance
    always @(negedge clk) begin
        if (ls_b === 1'b1) begin
            if (q_lb.size() == 0) unexp("b_line_start");
            else line_cmp("b", q_lb.pop_front(), 32'(col_b), 32'(row_b), 32'(fs_b), 32'(fc_b));
        end
        if (fs_b === 1'b1) chk("b_fs_with_ls", 32'(ls_b), 1);
    end

    // Monitor for the tiny-mode instance
    always @(negedge clk) begin
        if (ls_c === 1'b1) begin
            if (q_lc.size() == 0) unexp("c_line_start");
            else line_cmp("c", q_lc.pop_front(), 32'(col_c), 32'(row_c), 32'(fs_c), 32'(fc_c));
        end
        if (fs_c === 1'b1) chk("c_fs_with_ls", 32'(ls_c), 1);
    end

    logic        hs_prev_a = 1'bx;
    logic        hs_low_a = 1'b0;
    int unsigned fall_cyc_a, fall_col_a;

    // h_sync pulse monitor (default instance): compare fall position and low width on each rise
    always @(negedge clk) begin
        if (hs_prev_a === 1'b1 && hs_a === 1'b0) begin
            fall_cyc_a <= cyc;
            fall_col_a <= 32'(col_a);
            hs_low_a   <= 1'b1;
        end else if (hs_low_a && hs_a === 1'b1) begin
            hs_low_a <= 1'b0;
            if (q_sa.size() == 0) begin
                unexp("a_hsync_pulse");
            end else begin
                chk("a_hs_fall_cycle", fall_cyc_a, q_sa[0].stamp);
                chk("a_hs_fall_col", fall_col_a, q_sa[0].v1);
                chk("a_hs_low_clocks", cyc - fall_cyc_a, q_sa[0].v2);
                void'(q_sa.pop_front());
            end
        end
        hs_prev_a <= hs_a;
    end

    initial begin
        rst_a = 1'b1; run_a = 1'b1;
        rst_b = 1'b1; run_b = 1'b1;
        rst_c = 1'b1; run_c = 1'b1;
        repeat (3) @(negedge clk);
        chk_rst("a", 32'(col_a), 32'(row_a), 32'(fc_a), hs_a, vs_a, in_a, cmd_a, ls_a, fs_a, 1'b1);
        chk_rst("b", 32'(col_b), 32'(row_b), 32'(fc_b), hs_b, vs_b, in_b, cmd_b, ls_b, fs_b, 1'b0);
        chk_rst("c", 32'(col_c), 32'(row_c), 32'(fc_c), hs_c, vs_c, in_c, cmd_c, ls_c, fs_c, 1'b1);
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        base  = cyc;

        // Default mode: line every 800 clocks, h_sync low cols 656..751
        for (int unsigned n = 1; n <= 3; n++) q_la.push_back(mk(base + 800 * n, n, 0, 0));
        for (int unsigned m = 0; m <= 2; m++) q_sa.push_back(mk(base + 800 * m + 656, 656, 96, 0));
        // PIX_DIV=2: line every 1600 clocks
        q_lb.push_back(mk(base + 1600, 1, 0, 0));
        // Tiny mode: 12-clock lines, 7 lines per frame, 2-bit frame count
        for (int unsigned n = 1; n <= 38; n++) begin
            q_lc.push_back(mk(base + 12 * n, n % 7, (n % 7 == 0) ? 1 : 0, (n / 7) % 4));
        end

        fork
            begin
                at_cyc(base + 1);
                chk("a_first_tick_col", 32'(col_a), 1);
                chk("a_first_tick_row", 32'(row_a), 0);
                at_cyc(base + 639);
                chk("a_col639_inactive", 32'(in_a), 0);
                at_cyc(base + 640);
                chk("a_col640_inactive", 32'(in_a), 1);
                chk("a_col640_cmd_en", 32'(cmd_a), 0);
                at_cyc(base + 656);
                chk("a_col656_col", 32'(col_a), 656);
                chk("a_col656_hsync", 32'(hs_a), 0);
                at_cyc(base + 2700);
                chk("a_pre_stop_col", 32'(col_a), 300);
                chk("a_pre_stop_row", 32'(row_a), 3);
                run_a = 1'b0;
                at_cyc(base + 2701);
                chk("a_stop_col", 32'(col_a), 300);
                chk("a_stop_row", 32'(row_a), 3);
                chk("a_stop_inactive", 32'(in_a), 1);
                chk("a_stop_cmd_en", 32'(cmd_a), 1);
                chk("a_stop_hsync", 32'(hs_a), 1);
                chk("a_stop_vsync", 32'(vs_a), 1);
                at_cyc(base + 2710);
                chk("a_hold_col", 32'(col_a), 300);
                chk("a_hold_row", 32'(row_a), 3);
                run_a = 1'b1;
                at_cyc(base + 2711);
                chk("a_resume_col", 32'(col_a), 301);
                chk("a_resume_row", 32'(row_a), 3);
                chk("a_resume_inactive", 32'(in_a), 0);
                chk("a_resume_cmd_en", 32'(cmd_a), 0);
            end
            begin
                at_cyc(base + 1);
                chk("b_col_j1", 32'(col_b), 0);
                at_cyc(base + 2);
                chk("b_col_j2", 32'(col_b), 1);
                at_cyc(base + 3);
                chk("b_col_j3", 32'(col_b), 1);
                at_cyc(base + 4);
                chk("b_col_j4", 32'(col_b), 2);
                at_cyc(base + 1311);
                chk("b_hsync_before", 32'(hs_b), 0);
                at_cyc(base + 1312);
                chk("b_hsync_rise", 32'(hs_b), 1);
                at_cyc(base + 1503);
                chk("b_hsync_last_high", 32'(hs_b), 1);
                at_cyc(base + 1504);
                chk("b_hsync_fall", 32'(hs_b), 0);
                at_cyc(base + 1601);
                chk("b_line_start_width", 32'(ls_b), 0);
                chk("b_col_after_wrap", 32'(col_b), 0);
                chk("b_row_after_wrap", 32'(row_b), 1);
            end
            begin
                at_cyc(base + 7);
                chk("c_col7_inactive", 32'(in_c), 0);
                chk("c_col7_hsync", 32'(hs_c), 1);
                at_cyc(base + 8);
                chk("c_col8_inactive", 32'(in_c), 1);
                at_cyc(base + 9);
                chk("c_col9_hsync", 32'(hs_c), 0);
                at_cyc(base + 11);
                chk("c_col11_hsync", 32'(hs_c), 1);
                at_cyc(base + 47);
                chk("c_r3c11_cmd_en", 32'(cmd_c), 0);
                chk("c_r3c11_inactive", 32'(in_c), 1);
                at_cyc(base + 48);
                chk("c_r4c0_cmd_en", 32'(cmd_c), 1);
                chk("c_r4c0_inactive", 32'(in_c), 1);
                chk("c_r4c0_vsync", 32'(vs_c), 1);
                at_cyc(base + 60);
                chk("c_r5_vsync", 32'(vs_c), 0);
                chk("c_r5_cmd_en", 32'(cmd_c), 1);
                at_cyc(base + 72);
                chk("c_r6_vsync", 32'(vs_c), 1);
                chk("c_r6_cmd_en", 32'(cmd_c), 1);
                at_cyc(base + 84);
                chk("c_r0_cmd_en", 32'(cmd_c), 0);
                chk("c_r0_inactive", 32'(in_c), 0);
                at_cyc(base + 463);
                chk("c_pre_rst_col", 32'(col_c), 7);
                chk("c_pre_rst_row", 32'(row_c), 3);
                chk("c_pre_rst_frame", 32'(fc_c), 1);
                rst_c = 1'b1;
                at_cyc(base + 464);
                chk_rst("c_mid", 32'(col_c), 32'(row_c), 32'(fc_c), hs_c, vs_c, in_c, cmd_c,
                        ls_c, fs_c, 1'b1);
                at_cyc(base + 466);
                rst_c = 1'b0;
                base2 = cyc;
                for (int unsigned n = 1; n <= 7; n++) begin
                    q_lc.push_back(mk(base2 + 12 * n, n % 7, (n == 7) ? 1 : 0, n / 7));
                end
                at_cyc(base2 + 90);
                run_c = 1'b0;
                at_cyc(base2 + 91);
                chk("c_stop_col", 32'(col_c), 6);
                chk("c_stop_inactive", 32'(in_c), 1);
                chk("c_stop_cmd_en", 32'(cmd_c), 1);
            end
        join

        @(negedge clk);
        chk("a_ls_pending", q_la.size(), 0);
        chk("b_ls_pending", q_lb.size(), 0);
        chk("c_ls_pending", q_lc.size(), 0);
        chk("a_hs_pending", q_sa.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
